// File: rtl/cpu_pkg.sv
// Shared control-path types for the milestone CPU: sequencer states,
// RV32I base opcodes and the opcode-class encoding used by decode.
package cpu_pkg;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned CLASS_W  = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_EXEC   = 4'd3,
    ST_MEM    = 4'd4,
    ST_WB     = 4'd5,
    ST_PCSET  = 4'd6,
    ST_PCINC  = 4'd7,
    ST_ERROR  = 4'd15
  } state_e;

  typedef enum logic [CLASS_W-1:0] {
    CLS_ALU    = 3'd0,
    CLS_LOAD   = 3'd1,
    CLS_STORE  = 3'd2,
    CLS_BRANCH = 3'd3,
    CLS_JUMP   = 3'd4,
    CLS_BAD    = 3'd5
  } op_class_e;

  localparam logic [OPCODE_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPCODE_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPCODE_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OPC_JALR   = 7'b1100111;

  // Map a major opcode onto the sequencing class that selects the phase path.
  function automatic op_class_e classify(input logic [OPCODE_W-1:0] opc);
    op_class_e cls;
    case (opc)
      OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: cls = CLS_ALU;
      OPC_LOAD:                               cls = CLS_LOAD;
      OPC_STORE:                              cls = CLS_STORE;
      OPC_BRANCH:                             cls = CLS_BRANCH;
      OPC_JAL, OPC_JALR:                      cls = CLS_JUMP;
      default:                                cls = CLS_BAD;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/opcode_class_dec.sv
// Combinational opcode-to-class decoder; shared by the sequencer and datapath.
module opcode_class_dec
  import cpu_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [2:0] op_class_c
);

  always_comb begin
    op_class_c = 3'(classify(opcode));
  end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer. Outputs are flopped from the
// next state so they line up with the state they belong to.
module cpu_seq_ctrl
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_load,
  output logic       reg_we,
  output logic       jump,
  output logic       branch,
  output logic       inc_pc,
  output logic       illegal,
  output logic [3:0] state
);

  state_e    state_q,   state_d;
  op_class_e cls_q,     cls_d;
  logic      jump_q,    jump_d;
  logic      branch_q,  branch_d;
  logic      mem_req_q, mem_req_d;
  logic      mem_we_q,  mem_we_d;
  logic      ir_load_q, ir_load_d;
  logic      reg_we_q,  reg_we_d;
  logic      inc_pc_q,  inc_pc_d;
  logic      illegal_q, illegal_d;

  logic [2:0] dec_raw_c;
  op_class_e  dec_cls_c;

  opcode_class_dec u_opcode_class_dec (
    .opcode     (opcode),
    .op_class_c (dec_raw_c)
  );

  assign dec_cls_c = op_class_e'(dec_raw_c);

  // Next state, latched PC selects, and registered strobes.
  always_comb begin
    state_d  = state_q;
    cls_d    = cls_q;
    jump_d   = jump_q;
    branch_d = branch_q;

    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (mem_ack) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        cls_d   = dec_cls_c;
        state_d = (dec_cls_c == CLS_BAD) ? ST_ERROR : ST_EXEC;
      end
      ST_EXEC: begin
        jump_d   = (cls_q == CLS_JUMP);
        branch_d = (cls_q == CLS_BRANCH) && branch_taken;
        case (cls_q)
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          CLS_BRANCH:          state_d = ST_PCSET;
          default:             state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (mem_ack) state_d = (cls_q == CLS_LOAD) ? ST_WB : ST_PCSET;
      end
      ST_WB: begin
        state_d = ST_PCSET;
      end
      ST_PCSET: begin
        state_d = ST_PCINC;
      end
      ST_PCINC: begin
        jump_d   = 1'b0;
        branch_d = 1'b0;
        state_d  = run ? ST_FETCH : ST_IDLE;
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_ERROR;
      end
    endcase

    mem_req_d = (state_d == ST_FETCH) || (state_d == ST_MEM);
    mem_we_d  = (state_d == ST_MEM) && (cls_d == CLS_STORE);
    ir_load_d = (state_d == ST_DECODE);
    reg_we_d  = (state_d == ST_WB);
    inc_pc_d  = (state_d == ST_PCINC);
    illegal_d = illegal_q || (state_d == ST_ERROR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cls_q     <= CLS_ALU;
      jump_q    <= 1'b0;
      branch_q  <= 1'b0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      ir_load_q <= 1'b0;
      reg_we_q  <= 1'b0;
      inc_pc_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      jump_q    <= jump_d;
      branch_q  <= branch_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
      ir_load_q <= ir_load_d;
      reg_we_q  <= reg_we_d;
      inc_pc_q  <= inc_pc_d;
      illegal_q <= illegal_d;
    end
  end

  assign mem_req = mem_req_q;
  assign mem_we  = mem_we_q;
  assign ir_load = ir_load_q;
  assign reg_we  = reg_we_q;
  assign jump    = jump_q;
  assign branch  = branch_q;
  assign inc_pc  = inc_pc_q;
  assign illegal = illegal_q;
  assign state   = 4'(state_q);

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed bench for cpu_seq_ctrl: per-instruction cycle counts, strobe
// placement, PC-select setup, illegal opcode and asynchronous reset.
module tb_cpu_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       run;
  logic [6:0] opcode;
  logic       branch_taken;
  logic       mem_ack;
  logic       mem_req;
  logic       mem_we;
  logic       ir_load;
  logic       reg_we;
  logic       jump;
  logic       branch;
  logic       inc_pc;
  logic       illegal;
  logic [3:0] state;

  int n_asserts = 0;
  int n_fails   = 0;

  cpu_seq_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .opcode       (opcode),
    .branch_taken (branch_taken),
    .mem_ack      (mem_ack),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .ir_load      (ir_load),
    .reg_we       (reg_we),
    .jump         (jump),
    .branch       (branch),
    .inc_pc       (inc_pc),
    .illegal      (illegal),
    .state        (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] outs();
    return {mem_req, mem_we, ir_load, reg_we, jump, branch, inc_pc, illegal};
  endfunction

  // Run one instruction from IDLE with run dropped after launch; ack waits are
  // counted in request cycles before the acked one.
  task automatic run_instr(input string nm, input logic [6:0] opc, input logic taken,
                           input int fwait, input int mwait,
                           input int e_inc, input int e_we_n, input int e_we_cyc,
                           input int e_mwe_n, input logic e_jmp, input logic e_br);
    int inc_cyc = 0, inc_n = 0, we_n = 0, we_cyc = 0, mwe_n = 0, mwe_bad = 0;
    int irl_n = 0, req_cnt = 0, st_after = 99;
    logic [3:0] prev_st = 4'd0;
    logic pj = 1'b0, pb = 1'b0, jmp_pre = 1'b0, br_pre = 1'b0;
    logic jmp_inc = 1'b0, br_inc = 1'b0;
    bit done = 0;
    opcode       = opc;
    branch_taken = taken;
    mem_ack      = 1'b0;
    run          = 1'b1;
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      step();
      run = 1'b0;
      if (reg_we) begin we_n++; we_cyc = cyc; end
      if (ir_load) irl_n++;
      if (mem_we) begin mwe_n++; if (state != 4'd4) mwe_bad++; end
      if (inc_pc) begin
        inc_n++;
        if (inc_cyc == 0) begin
          inc_cyc = cyc; jmp_inc = jump; br_inc = branch; jmp_pre = pj; br_pre = pb;
        end
      end
      if (inc_cyc != 0 && cyc == inc_cyc + 1) begin st_after = int'(state); done = 1; end
      pj = jump;
      pb = branch;
      if (state != prev_st) req_cnt = 0;
      prev_st = state;
      if (mem_req) begin
        mem_ack = (req_cnt == ((state == 4'd1) ? fwait : mwait));
        req_cnt++;
      end else begin
        mem_ack = 1'b0;
      end
    end
    mem_ack = 1'b0;
    check_eq({nm, " inc_pc cycle"}, inc_cyc, e_inc);
    check_eq({nm, " inc_pc width"}, inc_n, 1);
    check_eq({nm, " ir_load count"}, irl_n, 1);
    check_eq({nm, " reg_we count"}, we_n, e_we_n);
    check_eq({nm, " reg_we cycle"}, we_cyc, e_we_cyc);
    check_eq({nm, " mem_we count"}, mwe_n, e_mwe_n);
    check_eq({nm, " mem_we outside MEM"}, mwe_bad, 0);
    check_eq({nm, " jump before inc"}, 32'(jmp_pre), 32'(e_jmp));
    check_eq({nm, " jump at inc"}, 32'(jmp_inc), 32'(e_jmp));
    check_eq({nm, " branch before inc"}, 32'(br_pre), 32'(e_br));
    check_eq({nm, " branch at inc"}, 32'(br_inc), 32'(e_br));
    check_eq({nm, " state after PCINC"}, st_after, 0);
  endtask

  initial begin
    logic [7:0] strobes;
    int         req_seen;
    rst = 1'b0; run = 1'b0; opcode = 7'd0; branch_taken = 1'b0; mem_ack = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("reset outputs", 32'(outs()), 0);
    check_eq("reset state", 32'(state), 0);
    step();
    step();
    rst = 1'b0;
    step();
    check_eq("idle hold without run", 32'(state), 0);

    //        name      opcode      tkn fw mw inc we wecyc mwe jmp br
    run_instr("OP",     7'b0110011, 0,  0, 0, 6,  1, 4,    0,  0,  0);
    run_instr("BR_T",   7'b1100011, 1,  0, 0, 5,  0, 0,    0,  0,  1);
    run_instr("BR_NT",  7'b1100011, 0,  0, 0, 5,  0, 0,    0,  0,  0);
    run_instr("LOAD_W", 7'b0000011, 0,  3, 3, 13, 1, 11,   0,  0,  0);
    run_instr("STORE",  7'b0100011, 1,  0, 0, 6,  0, 0,    1,  0,  0);
    run_instr("JAL",    7'b1101111, 0,  0, 0, 6,  1, 4,    0,  1,  0);
    run_instr("JALR_W", 7'b1100111, 0,  2, 0, 8,  1, 6,    0,  1,  0);
    run_instr("LUI",    7'b0110111, 1,  0, 0, 6,  1, 4,    0,  0,  0);

    // Illegal opcode: stuck in ERROR, acks ignored, no further requests.
    opcode = 7'b1111111; run = 1'b1; mem_ack = 1'b1;
    step();
    check_eq("bad fetch state", 32'(state), 1);
    check_eq("bad fetch mem_req", 32'(mem_req), 1);
    step();
    check_eq("bad decode ir_load", 32'(ir_load), 1);
    step();
    check_eq("bad error state", 32'(state), 15);
    check_eq("bad illegal set", 32'(illegal), 1);
    strobes = 8'd0;
    req_seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      strobes = strobes | (outs() & 8'hFE);
      if (mem_req) req_seen++;
    end
    check_eq("error strobes", 32'(strobes), 0);
    check_eq("error mem_req count", req_seen, 0);
    check_eq("error illegal sticky", 32'(illegal), 1);
    check_eq("error state hold", 32'(state), 15);

    // Reset clears ERROR; then reset again asynchronously mid-MEM.
    run = 1'b0; mem_ack = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("rst clears illegal", 32'(illegal), 0);
    check_eq("rst leaves error", 32'(state), 0);
    opcode = 7'b0000011; run = 1'b1;
    step();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    step();
    step();
    check_eq("mid-MEM state", 32'(state), 4);
    check_eq("mid-MEM mem_req", 32'(mem_req), 1);
    #3 rst = 1'b1;
    #1;
    check_eq("async rst outputs", 32'(outs()), 0);
    check_eq("async rst state", 32'(state), 0);
    run = 1'b0;
    step();
    rst = 1'b0;
    step();
    check_eq("post rst quiet", 32'({outs(), state}), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule

// File: doc/cpu_seq_ctrl.md
# cpu_seq_ctrl

Multi-cycle control sequencer for the milestone CPU. Steps each instruction through fetch, decode, execute, memory and writeback phases. Drives the instruction-memory/data-memory request handshake and the register-file write enable. Produces the `inc_pc`, `jump` and `branch` controls consumed by the program counter: `inc_pc` is a clean registered pulse, and `jump`/`branch` are stable across its rising edge.

## Interface
Parameters: none.

Ports:
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `run` in 1: level; leaving IDLE requires `run=1`.
- `opcode` in 7: `instr[6:0]` from the instruction register, valid from DECODE onward.
- `branch_taken` in 1: ALU compare result, valid in EXEC.
- `mem_ack` in 1: memory completion, sampled while `mem_req=1`.
- `mem_req` out 1: memory request, held until acked.
- `mem_we` out 1: 1 means store; 0 means read or fetch.
- `ir_load` out 1: one-cycle pulse that loads the instruction register.
- `reg_we` out 1: one-cycle register-file write strobe.
- `jump` out 1: PC selects `jump_addr`.
- `branch` out 1: PC selects `branch_addr`.
- `inc_pc` out 1: one-cycle PC update pulse.
- `illegal` out 1: sticky; set on an unknown opcode.
- `state` out 4: current state, for debug.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, PCSET, PCINC, ERROR. All outputs are registered (Moore) functions of state, plus latched `jump`/`branch`.
- IDLE → FETCH when `run=1`, otherwise stay.
- FETCH: `mem_req=1`, `mem_we=0`. On `mem_ack=1`, pulse `ir_load` and go to DECODE. With no ack, wait indefinitely.
- DECODE: classify `opcode`, then go to EXEC. Unknown opcode → ERROR.
- Opcode classes:
  - OP 0110011, OP-IMM 0010011, LUI 0110111, AUIPC 0010111: EXEC→WB.
  - LOAD 0000011: EXEC→MEM→WB.
  - STORE 0100011: EXEC→MEM→PCSET.
  - BRANCH 1100011: EXEC→PCSET.
  - JAL 1101111, JALR 1100111: EXEC→WB.
- EXEC:
  - BRANCH latches `branch <= branch_taken`.
  - JAL/JALR latch `jump <= 1`.
  - All other classes clear both.
- MEM: `mem_req=1`, `mem_we=1` for STORE and 0 for LOAD; hold until `mem_ack`.
- WB: `reg_we=1` for exactly one cycle, then go to PCSET. JAL/JALR write back the pre-update `pc_addr_plus`, because WB precedes the PC update.
- PCSET: `jump`/`branch` held, `inc_pc=0`. This is the setup cycle. Next state is PCINC.
- PCINC: `inc_pc=1` for one cycle, `jump`/`branch` still held. Next: FETCH if `run=1`, else IDLE. `jump`/`branch` clear on leaving PCINC.
- ERROR: `illegal=1` and all strobes 0. Only `rst` exits.
- `jump` and `branch` are never both 1.

## Timing
- Reset values: state IDLE; `mem_req`, `mem_we`, `ir_load`, `reg_we`, `jump`, `branch`, `inc_pc`, `illegal` all 0.
- Cycles per instruction, with `mem_ack` in the first request cycle:
  - ALU/LUI/AUIPC/JAL/JALR: 6 (FETCH, DECODE, EXEC, WB, PCSET, PCINC).
  - LOAD: 7.
  - STORE: 6.
  - BRANCH: 5.
- Each extra memory wait cycle adds 1.
- `mem_req` rises on entry to FETCH/MEM and falls in the cycle after `mem_ack` is sampled. `mem_ack` outside FETCH/MEM is ignored.
- `jump`/`branch` are stable for at least 1 full cycle before the `inc_pc` rising edge and through its high cycle.
- Dropping `run` mid-instruction completes that instruction, then goes to IDLE after PCINC.
- Mid-operation `rst` clears all outputs asynchronously, including an outstanding `mem_req`. No partial `reg_we` or `inc_pc` is emitted.

## Structure
- Shared package `cpu_pkg` holds:
  - the state enum (4-bit encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, PCSET=6, PCINC=7, ERROR=15);
  - opcode constants;
  - the opcode-class typedef (ALU, LOAD, STORE, BRANCH, JUMP, BAD).
- One sub-module, `opcode_class_dec`: combinational opcode → class decoder, reusable by the datapath.

## Test plan
- Reset, then `run=1`, OP opcode, `mem_ack` in the first FETCH cycle → `inc_pc` pulses at cycle 6 with `jump=0`, `branch=0`; `reg_we` high exactly in cycle 4.
- BRANCH with `branch_taken=1` → `branch=1` from PCSET through PCINC and `reg_we` never asserts. Repeat with `branch_taken=0` → `branch=0`. `inc_pc` pulses at cycle 5 in both cases.
- LOAD with `mem_ack` delayed 3 cycles in both FETCH and MEM → 13 cycles total; `mem_we=0` throughout; `reg_we` once.
- STORE → `mem_we=1` only in MEM; JAL → `jump=1` set up one cycle before `inc_pc`; no `reg_we` on STORE.
- Opcode 1111111 → ERROR, `illegal=1`, no further `mem_req`. Assert `rst` mid-MEM on a subsequent run → all outputs 0 immediately, state IDLE.
